// File: rtl/led_trail_pwm.sv
// Eight-channel LED trail: pattern bits load full brightness, which then decays on a slow tick and drives PWM outputs.
// Define LED_TRAIL_GAMMA_EN to apply square-law gamma correction to the PWM duty; default build is linear.
module led_trail_pwm #(
    parameter int DECAY_DIV  = 15_999,
    parameter int DECAY_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pat_in,
    output logic [7:0] led,
    output logic       active
);

    localparam int             PW      = (DECAY_DIV < 1) ? 1 : $clog2(DECAY_DIV + 1);
    localparam logic [PW-1:0]  DIV_MAX = PW'(DECAY_DIV);
    localparam logic [7:0]     STEP    = 8'(DECAY_STEP);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    level_q [8];
    logic [7:0]    level_d [8];
    logic [7:0]    duty    [8];
    logic [7:0]    led_q, led_d;
    logic          active_q, active_d;
`ifdef LED_TRAIL_GAMMA_EN
    logic [15:0]   sq      [8];
`endif

    always_comb begin
        tick      = (presc_q == DIV_MAX);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
    end

    // A pattern bit reloads full brightness even on a tick cycle; decay saturates at zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            level_d[i] = level_q[i];
            if (pat_in[i]) begin
                level_d[i] = 8'd255;
            end else if (tick) begin
                level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : 8'd0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef LED_TRAIL_GAMMA_EN
            sq[i]   = 16'(level_q[i]) * 16'(level_q[i]) + 16'd255;
            duty[i] = sq[i][15:8];
`else
            duty[i] = level_q[i];
`endif
        end
    end

    // The counter tops out at 254, so duty 255 is always on and duty 0 always off.
    always_comb begin
        led_d    = 8'h00;
        active_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            led_d[i] = (pwm_cnt_q < duty[i]);
            active_d = active_d | (level_q[i] != 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_cnt_q <= 8'd0;
            led_q     <= 8'h00;
            active_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= 8'd0;
            end
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            active_q  <= active_d;
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led    = led_q;
    assign active = active_q;

endmodule

// File: doc/led_trail_pwm.md
LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 SHALL have parameter DECAY_DIV, default 15_999: decay tick period minus one, in clk cycles (1 ms at 16 MHz).
REQ-002 SHALL have parameter DECAY_STEP, default 8: brightness subtracted per decay tick, legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock, 16 MHz.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port pat_in  input  8  LED pattern from the upstream scanner; bit i high lights LED i at full brightness.
REQ-006 SHALL have port led  output  8  PWM-driven LED outputs, registered.
REQ-007 SHALL have port active  output  1  registered; high when any channel brightness is nonzero.

Function
REQ-008 SHALL keep one 8-bit brightness level per channel, level[0..7].
REQ-009 SHALL run a prescaler counting 0..DECAY_DIV, wrapping to 0, and assert a one-cycle tick when the count equals DECAY_DIV.
REQ-010 SHALL, when pat_in[i]=1 in cycle N, set level[i]=255 in cycle N+1, whether or not tick is asserted; load has priority over decay.
REQ-011 SHALL, on tick with pat_in[i]=0, set level[i]=level[i]-DECAY_STEP, saturating at 0; no wrap-around.
REQ-012 SHALL otherwise hold level[i].
REQ-013 SHALL run a free-running 8-bit PWM counter pwm_cnt counting 0..254, period 255 cycles, wrapping 254->0.
REQ-014 SHALL compute led[i] as a registered (pwm_cnt < duty[i]), where duty[i] is the effective duty defined under Configuration.
REQ-015 SHALL therefore hold led[i] constantly high for duty 255 and constantly low for duty 0.
REQ-016 SHALL give a latency of 2 cycles from pat_in[i] rising to led[i] high, at any pwm_cnt value.
REQ-017 SHALL compute active as the registered OR over i of (level[i]!=0), with 1 cycle latency from level.
REQ-018 SHALL bring a channel from 255 to 0 in ceil(255/DECAY_STEP) ticks after pat_in[i] falls; with defaults, 32 ticks = 32 ms.
REQ-019 SHALL treat all channels independently; simultaneous loads and decays on different channels have no interaction.

Reset
REQ-020 SHALL, on rst=1 at a clk edge, clear the prescaler, pwm_cnt, all level[i], led to 8'h00 and active to 0.
REQ-021 SHALL give rst priority over pat_in and tick; a reset mid-fade discards all brightness.
REQ-022 SHALL, on the first cycle after rst falls, resume with prescaler=0 and pwm_cnt=0.

Configuration
REQ-023 SHALL use macro LED_TRAIL_GAMMA_EN to select gamma correction.
REQ-024 SHALL, with LED_TRAIL_GAMMA_EN defined, use duty[i] = (level[i]*level[i]+255)>>8, computed in 16 bits (0->0, 1->1, 128->64, 255->255).
REQ-025 SHALL, without LED_TRAIL_GAMMA_EN, use duty[i] = level[i] (linear).
REQ-026 SHALL keep all latencies and reset behaviour identical in both builds.

Verification (DECAY_DIV=3, DECAY_STEP=64 unless stated)
REQ-027 SHALL cover reset: drive pat_in=8'hFF during rst -> led=8'h00 and active=0 throughout; after release, led=8'hFF from the 2nd cycle onward.
REQ-028 SHALL cover the fade sequence: pulse pat_in=8'h01 for 1 cycle, then 8'h00 -> level[0] steps 255,191,127,63,0 on successive ticks 4 cycles apart; active falls 1 cycle after level reaches 0.
REQ-029 SHALL cover PWM duty in the linear build: hold level[0] at 127 -> led[0] high exactly 127 of every 255 cycles.
REQ-030 SHALL cover load/decay collision: assert pat_in[3]=1 on the tick cycle -> level[3]=255 next cycle, with no decrement applied.
REQ-031 SHALL cover saturation: DECAY_STEP=200 with level 255 -> 55, then 0 on the next tick, then held at 0 (no wrap to 111).
REQ-032 SHALL cover gamma: in the LED_TRAIL_GAMMA_EN build, level 128 -> led high 64 of 255 cycles; in the linear build, 128 of 255.
